param_stack: RTL and testbench

- Parametrised hardware LIFO stack. It is the generalised successor to the CPU's fixed 16-bit data/return stack.
- Exposes top-of-stack and next-of-stack as combinational reads, so the ALU sees T and N without a pop cycle.
- Adds depth tracking, full/empty status, and sticky overflow/underflow error flags.
- Instantiated inside cpu for the data stack and the return stack, with independent WIDTH/DEPTH.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/stack_ram.sv | 46 ++++
 rtl/param_stack.sv | 157 +++++++++++++++
 tb/tb_param_stack.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, default stack depths and the stack operation encoding.
// No ports. Used by param_stack and by cpu for its data and return stacks.
package cpu_pkg;

  localparam int unsigned WORD_WIDTH   = 16;
  localparam int unsigned DSTACK_DEPTH = 16;
  localparam int unsigned RSTACK_DEPTH = 16;

  // Encoding matches {push, pop}, so a plain cast of that pair decodes the operation.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_POP  = 2'b01,
    ST_PUSH = 2'b10,
    ST_REPL = 2'b11
  } stack_op_t;

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array for param_stack.
// One synchronous write port and two asynchronous read ports; a third read port
// is present only when PARAM_STACK_PEEK_EN is defined.
// Ports:
//   i_clock            write clock
//   i_we/i_waddr/i_wdata  write port
//   i_raddr0/o_rdata0  read port 0 (top)
//   i_raddr1/o_rdata1  read port 1 (next)
//   i_raddr2/o_rdata2  read port 2 (peek, PARAM_STACK_PEEK_EN only)
module stack_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr0,
  output logic [WIDTH-1:0] o_rdata0,
  input  logic [AW-1:0]    i_raddr1,
`ifdef PARAM_STACK_PEEK_EN
  output logic [WIDTH-1:0] o_rdata1,
  input  logic [AW-1:0]    i_raddr2,
  output logic [WIDTH-1:0] o_rdata2
`else
  output logic [WIDTH-1:0] o_rdata1
`endif
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; the owner masks reads by its depth count.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];
`ifdef PARAM_STACK_PEEK_EN
  assign o_rdata2 = r_mem[i_raddr2];
`endif

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with combinational top/next reads, depth tracking,
// full/empty status and sticky overflow/underflow flags.
// Optional feature macro: PARAM_STACK_PEEK_EN (adds i_peek_idx / o_peek).
// Ports:
//   i_clock, i_reset_n (synchronous, active low)
//   i_push, i_pop, i_data   stack operation and write data
//   i_clear_err             clears sticky error flags (a same-cycle set wins)
//   o_top, o_next           T and N, zero when not present
//   o_depth, o_empty, o_full
//   o_overflow, o_underflow sticky error flags
//   i_peek_idx, o_peek      entry i_peek_idx below top (PARAM_STACK_PEEK_EN only)
module param_stack
  import cpu_pkg::*;
#(
  parameter  int unsigned WIDTH = WORD_WIDTH,
  parameter  int unsigned DEPTH = DSTACK_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear_err,
  output logic [WIDTH-1:0] o_top,
  output logic [WIDTH-1:0] o_next,
  output logic [PTR_W-1:0] o_depth,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
`ifdef PARAM_STACK_PEEK_EN
  output logic             o_underflow,
  input  logic [PTR_W-1:0] i_peek_idx,
  output logic [WIDTH-1:0] o_peek
`else
  output logic             o_underflow
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] r_depth;
  logic             r_overflow;
  logic             r_underflow;

  stack_op_t        w_op;
  logic             w_empty;
  logic             w_full;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [PTR_W-1:0] w_depth_nxt;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [AW-1:0]    w_top_addr;
  logic [AW-1:0]    w_next_addr;
  logic [WIDTH-1:0] w_top_raw;
  logic [WIDTH-1:0] w_next_raw;

  assign w_op    = stack_op_t'({i_push, i_pop});
  assign w_empty = (r_depth == '0);
  assign w_full  = (r_depth == PTR_W'(DEPTH));

  // Address arithmetic wraps when depth is small; those reads are masked below.
  assign w_top_addr  = AW'(r_depth - PTR_W'(1));
  assign w_next_addr = AW'(r_depth - PTR_W'(2));

  // Operation decode: next depth, write enable and error set conditions.
  always_comb begin
    w_we        = 1'b0;
    w_waddr     = '0;
    w_depth_nxt = r_depth;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    case (w_op)
      ST_PUSH: begin
        if (w_full) begin
          w_ovf_set = 1'b1;
        end else begin
          w_we        = 1'b1;
          w_waddr     = AW'(r_depth);
          w_depth_nxt = r_depth + PTR_W'(1);
        end
      end
      ST_POP: begin
        if (w_empty) begin
          w_unf_set = 1'b1;
        end else begin
          w_depth_nxt = r_depth - PTR_W'(1);
        end
      end
      ST_REPL: begin
        w_we = 1'b1;
        if (w_empty) begin
          // Replace on an empty stack still lands the value, but flags the missing operand.
          w_unf_set   = 1'b1;
          w_waddr     = '0;
          w_depth_nxt = PTR_W'(1);
        end else begin
          w_waddr = w_top_addr;
        end
      end
      default: begin
      end
    endcase
  end

  // Depth counter and sticky flags; reset dominates every operation.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_depth     <= w_depth_nxt;
      r_overflow  <= w_ovf_set | (r_overflow & ~i_clear_err);
      r_underflow <= w_unf_set | (r_underflow & ~i_clear_err);
    end
  end

`ifdef PARAM_STACK_PEEK_EN
  logic [AW-1:0]    w_peek_addr;
  logic [WIDTH-1:0] w_peek_raw;

  assign w_peek_addr = AW'(r_depth - PTR_W'(1) - i_peek_idx);
  assign o_peek      = (i_peek_idx < r_depth) ? w_peek_raw : '0;
`endif

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clock  (i_clock),
    .i_we     (w_we & i_reset_n),
    .i_waddr  (w_waddr),
    .i_wdata  (i_data),
    .i_raddr0 (w_top_addr),
    .o_rdata0 (w_top_raw),
    .i_raddr1 (w_next_addr),
`ifdef PARAM_STACK_PEEK_EN
    .o_rdata1 (w_next_raw),
    .i_raddr2 (w_peek_addr),
    .o_rdata2 (w_peek_raw)
`else
    .o_rdata1 (w_next_raw)
`endif
  );

  assign o_top       = w_empty ? '0 : w_top_raw;
  assign o_next      = (r_depth >= PTR_W'(2)) ? w_next_raw : '0;
  assign o_depth     = r_depth;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (DEPTH = 4): directed sequences followed by
// random traffic, checked against a queue-based LIFO reference model.
module tb_param_stack;

  localparam int unsigned W     = 16;
  localparam int unsigned D     = 4;
  localparam int unsigned PW    = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push;
  logic          pop;
  logic [W-1:0]  data;
  logic          clr;
  logic [W-1:0]  top;
  logic [W-1:0]  nxt;
  logic [PW-1:0] depth;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          unf;
`ifdef PARAM_STACK_PEEK_EN
  logic [PW-1:0] peek_idx;
  logic [W-1:0]  peek;
`endif

  always #5 clk = ~clk;

  param_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_push      (push),
    .i_pop       (pop),
    .i_data      (data),
    .i_clear_err (clr),
    .o_top       (top),
    .o_next      (nxt),
    .o_depth     (depth),
    .o_empty     (empty),
    .o_full      (full),
    .o_overflow  (ovf),
`ifdef PARAM_STACK_PEEK_EN
    .o_underflow (unf),
    .i_peek_idx  (peek_idx),
    .o_peek      (peek)
`else
    .o_underflow (unf)
`endif
  );

  typedef struct {
    logic [W-1:0] top;
    logic [W-1:0] nxt;
    int           depth;
    logic         empty;
    logic         full;
    logic         ovf;
    logic         unf;
    logic [W-1:0] peek;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model[$];
  logic         m_ovf;
  logic         m_unf;
  int           checks = 0;
  int           errors = 0;
  bit           done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances and the expected post-edge state is queued.
  task automatic step(input logic p, input logic q, input logic [W-1:0] d,
                      input logic c, input logic r);
    exp_t e;
    int   n;
    int   pidx;
    @(negedge clk);
    push = p; pop = q; data = d; clr = c; rst_n = r;
    pidx = $urandom_range(0, D);
`ifdef PARAM_STACK_PEEK_EN
    peek_idx = PW'(pidx);
`endif
    if (!r) begin
      model.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (c) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (p && q) begin
        if (model.size() == 0) begin
          m_unf = 1'b1;
          model.push_back(d);
        end else begin
          model[model.size()-1] = d;
        end
      end else if (p) begin
        if (model.size() == D) m_ovf = 1'b1;
        else                   model.push_back(d);
      end else if (q) begin
        if (model.size() == 0) m_unf = 1'b1;
        else                   void'(model.pop_back());
      end
    end
    n       = model.size();
    e.depth = n;
    e.top   = (n >= 1) ? model[n-1] : '0;
    e.nxt   = (n >= 2) ? model[n-2] : '0;
    e.empty = (n == 0);
    e.full  = (n == D);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.peek  = (pidx < n) ? model[n-1-pidx] : '0;
    sb.push_back(e);
  endtask

  task automatic do_push(input logic [W-1:0] d);
    step(1'b1, 1'b0, d, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: each post-edge sample is compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("top",       32'(top),   32'(e.top));
        chk("next",      32'(nxt),   32'(e.nxt));
        chk("depth",     32'(depth), 32'(e.depth));
        chk("empty",     32'(empty), 32'(e.empty));
        chk("full",      32'(full),  32'(e.full));
        chk("overflow",  32'(ovf),   32'(e.ovf));
        chk("underflow", 32'(unf),   32'(e.unf));
`ifdef PARAM_STACK_PEEK_EN
        chk("peek",      32'(peek),  32'(e.peek));
`endif
      end
    end
  end

  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    logic p, q, c, r;
    int   roll;
    push = 1'b0; pop = 1'b0; data = '0; clr = 1'b0; rst_n = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;
`ifdef PARAM_STACK_PEEK_EN
    peek_idx = '0;
`endif
    do_reset();
    do_reset();

    // Three pushes: T/N/depth.
    do_push(16'h1100); do_push(16'h2200); do_push(16'h3300);

    // Fill to full, overflow on the fifth push, then clear the flag.
    do_reset();
    for (int i = 1; i <= 5; i++) do_push(W'(i));
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Underflow from empty, then replace on empty.
    do_reset();
    step(1'b0, 1'b1, '0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b1);

    // Replace at depth 2, then replace while full raises nothing.
    do_reset();
    do_push(16'h0011); do_push(16'h0022);
    step(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b1);
    do_push(16'h0033); do_push(16'h0044);
    step(1'b1, 1'b1, 16'h5555, 1'b0, 1'b1);

    // Error set and clear in the same cycle: set wins.
    step(1'b1, 1'b0, 16'h6666, 1'b1, 1'b1);

    // Reset together with push at depth 3.
    do_reset();
    do_push(16'h0001); do_push(16'h0002); do_push(16'h0003);
    step(1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
    do_push(16'h0009);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      roll = $urandom_range(0, 99);
      r = (roll >= 3);
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 6);
      step(p, q, W'($urandom), c, r);
    end

    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
